// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer that drives an external 1-bit full adder LSB first.
// Optional signed-overflow output ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_shift_q, a_shift_d;
    logic [WIDTH-1:0] b_shift_q, b_shift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_shift_q <= '0;
            b_shift_q <= '0;
            result_q  <= '0;
            count_q   <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_shift_q <= a_shift_d;
            b_shift_q <= b_shift_d;
            result_q  <= result_d;
            count_q   <= count_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        a_shift_d = a_shift_q;
        b_shift_d = b_shift_q;
        result_d  = result_q;
        count_d   = count_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_shift_d = op_a;
                    b_shift_d = op_b;
                    carry_d   = cin;
                    count_d   = '0;
                    result_d  = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                result_d  = {fa_sum, result_q[WIDTH-1:1]};
                carry_d   = fa_carry;
                a_shift_d = a_shift_q >> 1;
                b_shift_d = b_shift_q >> 1;
                count_d   = count_q + CW'(1);
                // Final bit: publish carry-out so it is valid alongside done.
                if (count_q == CW'(WIDTH - 1)) begin
                    cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_carry;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign fa_a   = a_shift_q[0];
    assign fa_b   = b_shift_q[0];
    assign fa_c   = carry_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: behavioural full adder plus an
// arithmetic reference model (a + b + cin) for result, carry and overflow.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         cin;
    logic         fa_sum, fa_carry;
    logic         fa_a, fa_b, fa_c;
    logic         busy, done;
    logic [W-1:0] result;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {fa_carry, fa_sum} = 2'(fa_a) + 2'(fa_b) + 2'(fa_c);

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .fa_sum   (fa_sum),
        .fa_carry (fa_carry),
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_c     (fa_c),
        .busy     (busy),
        .done     (done),
        .result   (result),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf      (ovf),
`endif
        .cout     (cout)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full operation; restart_at >= 0 re-pulses start at that RUN cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input int restart_at);
        logic [W:0] exp_sum;
        logic       exp_ovf;
        int         cyc;
        int         extra_done;
        exp_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        exp_ovf = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);
        @(negedge clk);
        op_a = a; op_b = b; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
        check_val("first_bits", {61'd0, fa_a, fa_b, fa_c}, {61'd0, a[0], b[0], ci});
        cyc = 0;
        while (!done && cyc < 4 * W) begin
            check_val("busy_run", 64'(busy), 64'd1);
            start = (cyc == restart_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check_val("latency", 64'(cyc), 64'(W));
        check_val("done", 64'(done), 64'd1);
        check_val("busy_done", 64'(busy), 64'd0);
        check_val("result", 64'(result), 64'(exp_sum[W-1:0]));
        check_val("cout", 64'(cout), 64'(exp_sum[W]));
`ifdef SERIAL_ADDER_OVF_EN
        check_val("ovf", 64'(ovf), 64'(exp_ovf));
`endif
        extra_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        check_val("single_done", 64'(extra_done), 64'd0);
        check_val("busy_idle", 64'(busy), 64'd0);
        check_val("result_hold", 64'(result), 64'(exp_sum[W-1:0]));
        check_val("cout_hold", 64'(cout), 64'(exp_sum[W]));
    endtask

    initial begin
        logic [W:0] exp_sum;
        int         last_done;
        int         n_done;
        int         saw_done;

        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        #1;
        check_val("rst_outs", {57'd0, busy, done, cout, fa_a, fa_b, fa_c, 1'b0}, 64'd0);
        check_val("rst_result", 64'(result), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_op(8'h3C, 8'h05, 1'b0, -1);
        run_op(8'hFF, 8'h01, 1'b0, -1);
        run_op(8'h7F, 8'h01, 1'b0, -1);
        run_op(8'hFF, 8'hFF, 1'b1, 3);
        run_op(8'h00, 8'h00, 1'b0, -1);

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_result", 64'(result), 64'd0);
        check_val("abort_fa", {61'd0, fa_a, fa_b, fa_c}, 64'd0);
        saw_done = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (done) saw_done++;
        end
        check_val("abort_no_done", 64'(saw_done), 64'd0);
        run_op(8'h01, 8'h01, 1'b0, -1);

        for (int i = 0; i < 20; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), (i % 4 == 0) ? int'($urandom_range(0, W - 1)) : -1);

        // Back-to-back with start held high.
        @(negedge clk);
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
        exp_sum = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin};
        start = 1'b1;
        last_done = -1;
        n_done = 0;
        for (int cyc = 0; cyc < 5 * (W + 2) + 4; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                check_val("b2b_result", 64'(result), 64'(exp_sum[W-1:0]));
                check_val("b2b_cout", 64'(cout), 64'(exp_sum[W]));
                if (last_done >= 0) check_val("b2b_period", 64'(cyc - last_done), 64'(W + 2));
                last_done = cyc;
                n_done++;
                op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
                exp_sum = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin};
            end
        end
        start = 1'b0;
        check_val("b2b_count", 64'(n_done >= 4), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial addition sequencer that drives a single external one-bit full adder stage, LSB first, one bit per clock.
- Latches two WIDTH-bit operands and a carry-in, presents one bit pair plus the stored carry to the full adder each cycle, and captures the returned sum and carry.
- Sits directly upstream and downstream of the full adder: it feeds the adder's three inputs and consumes its sum and carry outputs.
- Assembles the WIDTH-bit result and the final carry-out, then signals completion.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- op_a  input  WIDTH  operand A; sampled on the accepted start.
- op_b  input  WIDTH  operand B; sampled on the accepted start.
- cin  input  1  carry-in; sampled on the accepted start.
- fa_sum  input  1  sum bit returned by the full adder.
- fa_carry  input  1  carry bit returned by the full adder.
- fa_a  output  1  bit to full adder input A; equals a_shift[0].
- fa_b  output  1  bit to full adder input B; equals b_shift[0].
- fa_c  output  1  carry to full adder input C; equals carry_reg.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- result  output  WIDTH  sum; holds until the next accepted start.
- cout  output  1  final carry; holds with result.

Behaviour:
- Reset (asynchronous): state=IDLE. a_shift, b_shift, result, count, carry_reg, cout, busy and done all clear to 0. fa_a, fa_b and fa_c are therefore 0.
- States:
  - IDLE: start=1 loads a_shift=op_a, b_shift=op_b, carry_reg=cin, count=0, clears result. Next state RUN. start=0 stays in IDLE.
  - RUN: each cycle
    - result <= {fa_sum, result[WIDTH-1:1]}
    - carry_reg <= fa_carry
    - a_shift and b_shift shift right one bit, filling with 0
    - count <= count+1
  - RUN -> DONE on the cycle where count==WIDTH-1. That cycle's update is the last bit.
  - DONE: done=1 for exactly one cycle, cout=carry_reg, busy=0. Next state IDLE.
- The full adder is purely combinational. fa_sum and fa_carry are sampled in the same cycle fa_a, fa_b and fa_c are presented.
- Latency: accepted start at edge N -> RUN for edges N+1..N+WIDTH -> done high during the cycle after edge N+WIDTH. That is WIDTH+1 cycles from accepting start to done.
- start is ignored in RUN and in DONE; no queueing. Back-to-back operations are accepted at the earliest in the IDLE cycle after DONE.
- Operand inputs may change freely after start is accepted.
- result and cout stay unchanged in IDLE until the next accepted start. At that start, result clears and cout holds its old value until DONE.
- count is $clog2(WIDTH)+1 bits wide, so WIDTH=32 does not wrap early.
- Wrap-around: the sum is taken modulo 2^WIDTH; the overflow carry appears only on cout.
- Reset asserted mid-RUN aborts immediately to IDLE with all registers cleared. No done pulse is issued.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit). ovf is set in DONE to the two's-complement signed overflow: carry into the MSB XOR carry out of the MSB.
  - The carry into the MSB is captured from carry_reg on the last RUN cycle.
  - ovf resets to 0 and holds with result.
- Undefined: no ovf port and no extra logic.

Test Plan:
- Bench uses a behavioural full adder connected to the fa_* ports.
- WIDTH=8, op_a=8'h3C, op_b=8'h05, cin=0 -> done at cycle 9 after start; result=8'h41, cout=0.
- op_a=8'hFF, op_b=8'h01, cin=0 -> result=8'h00, cout=1. With SERIAL_ADDER_OVF_EN: ovf=0.
- op_a=8'h7F, op_b=8'h01, cin=0 with SERIAL_ADDER_OVF_EN -> result=8'h80, cout=0, ovf=1.
- op_a=8'hFF, op_b=8'hFF, cin=1 -> result=8'hFF, cout=1.
  - Same run: pulse start again at RUN cycle 3 -> ignored; busy stays high; exactly one done pulse.
- Start 8'hAA+8'h55, assert reset at RUN cycle 4 -> busy=0, result=0, no done pulse.
  - After reset, start 8'h01+8'h01 -> result=8'h02, cout=0.
- Back-to-back: hold start=1 continuously -> operations complete every WIDTH+2 cycles; each done is a single-cycle pulse; result updates only at each done.
